inv_round_engine: RTL and testbench

INV_ROUND_ENGINE -- requirements
Module: inv_round_engine

---
 rtl/inv_round_pkg.sv | 28 ++
 rtl/inv_round_step.sv | 17 +
 rtl/inv_round_engine.sv | 147 ++++++++++++++
 tb/tb_inv_round_engine.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/inv_round_pkg.sv
// Shared types and nibble-rotate helpers for the inverse round engine.
package inv_round_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [7:0][3:0] nib_vec_t;

    // Rotate amount for nibble i is floor(i/2).
    localparam logic [7:0][1:0] SHIFT_TBL = {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};

    function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] n);
        logic [7:0] d;
        d = {x, x} << n;
        return d[7:4];
    endfunction

    function automatic logic [3:0] rotr4(input logic [3:0] x, input logic [1:0] n);
        logic [7:0] d;
        d = {x, x} >> n;
        return d[3:0];
    endfunction

endpackage

// File: rtl/inv_round_step.sv
// One inverse round: nibble i of the current state moves to nibble (i+2) mod 8.
module inv_round_step
    import inv_round_pkg::*;
(
    input  logic [3:0] s,
    input  nib_vec_t   h_cur,
    output nib_vec_t   h_prev
);

    always_comb begin
        h_prev = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            h_prev[3'(i + 2)] = rotr4(h_cur[3'(i)], SHIFT_TBL[3'(i)]) ^ s;
        end
    end

endmodule

// File: rtl/inv_round_engine.sv
// Inverts up to MAX_ROUNDS rounds, one streamed S-nibble per accepted beat.
// Define INV_ROUND_SELFCHECK_EN to buffer nibbles and re-run the forward rounds.
module inv_round_engine
    import inv_round_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0][3:0] h_final,
    input  logic [4:0]      num_rounds,
    input  logic [3:0]      s_in,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [7:0][3:0] h_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            check_ok
);

    localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);

    state_t     state, state_nx;
    nib_vec_t   h_work, h_step;
    logic [4:0] rounds, cnt, n_sat;
    logic       accept, last_acc;

    assign n_sat    = (num_rounds > MAX_R) ? MAX_R : num_rounds;
    assign accept   = (state == RUN) && s_valid;
    assign last_acc = accept && (cnt == rounds - 5'd1);

    inv_round_step u_step (
        .s      (s_in),
        .h_cur  (h_work),
        .h_prev (h_step)
    );

`ifdef INV_ROUND_SELFCHECK_EN
    nib_vec_t   h_ref, h_chk, h_fwd;
    logic [3:0] nib_buf [MAX_ROUNDS];
    logic [3:0] chk_idx;
    logic       check_ok_r;

    // Forward round replayed from the newest stored nibble back to the oldest.
    always_comb begin
        h_fwd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            h_fwd[3'(i)] = rotl4(h_chk[3'(i + 2)] ^ nib_buf[chk_idx], SHIFT_TBL[3'(i)]);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            nib_buf[cnt[3:0]] <= s_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_ref      <= '0;
            h_chk      <= '0;
            chk_idx    <= '0;
            check_ok_r <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                h_ref      <= h_final;
                check_ok_r <= 1'b0;
            end
            if (last_acc) begin
                h_chk   <= h_step;
                chk_idx <= cnt[3:0];
            end
            if (state == CHECK) begin
                h_chk   <= h_fwd;
                chk_idx <= chk_idx - 4'd1;
                if (chk_idx == 4'd0) begin
                    check_ok_r <= (h_fwd == h_ref);
                end
            end
        end
    end

    assign check_ok = (state == DONE) && check_ok_r;
`else
    assign check_ok = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (n_sat == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_acc) begin
`ifdef INV_ROUND_SELFCHECK_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef INV_ROUND_SELFCHECK_EN
            CHECK: begin
                if (chk_idx == 4'd0) begin
                    state_nx = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            h_work <= '0;
            rounds <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                h_work <= h_final;
                rounds <= n_sat;
                cnt    <= '0;
            end else if (accept) begin
                h_work <= h_step;
                cnt    <= cnt + 5'd1;
            end
        end
    end

    assign s_ready   = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign h_out     = (state == DONE) ? h_work : '0;

endmodule

// File: tb/tb_inv_round_engine.sv
// Randomized bench for inv_round_engine against an integer-arithmetic reference.
module tb_inv_round_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] h_final = '0;
    logic [4:0]  num_rounds = '0;
    logic [3:0]  s_in = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] h_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        check_ok;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned sq[$];
    logic [31:0] last_h;

`ifdef INV_ROUND_SELFCHECK_EN
    localparam logic CHK_EXP = 1'b1;
`else
    localparam logic CHK_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    inv_round_engine #(.MAX_ROUNDS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .h_final    (h_final),
        .num_rounds (num_rounds),
        .s_in       (s_in),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .h_out      (h_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .check_ok   (check_ok)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Undo the forward round h[i] = rotl(h[(i+2)%8] ^ s, i/2) for each s in sq.
    function automatic logic [31:0] model_inv(input logic [31:0] h0, input int unsigned n);
        int unsigned h, nh, nib, sh, rot;
        h = h0;
        for (int unsigned r = 0; r < n; r++) begin
            nh = 0;
            for (int unsigned i = 0; i < 8; i++) begin
                nib = (h >> (4 * i)) & 15;
                sh  = i / 2;
                rot = ((nib >> sh) | (nib << (4 - sh))) & 15;
                nh  = nh | ((rot ^ sq[r]) << (4 * ((i + 2) % 8)));
            end
            h = nh;
        end
        return h;
    endfunction

    // fixed_s < 0 selects random nibbles; hold = cycles out_ready stays low.
    task automatic run_job(input logic [31:0] hf, input int unsigned n, input int fixed_s,
                           input bit gaps, input int unsigned hold);
        int unsigned n_eff, idx, cyc;
        logic [31:0] exp_h;
        bit sv, acc;
        n_eff = (n > 16) ? 16 : n;
        sq.delete();
        for (int unsigned k = 0; k < n_eff; k++)
            sq.push_back((fixed_s < 0) ? $urandom_range(0, 15) : 32'(fixed_s));
        exp_h = model_inv(hf, n_eff);

        @(negedge clk);
        start = 1'b1; h_final = hf; num_rounds = 5'(n);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 1;
        while (!out_valid && cyc < 200) begin
            sv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_valid = sv;
            s_in = (idx < n_eff) ? 4'(sq[idx]) : 4'($urandom_range(0, 15));
            acc = sv && s_ready;
            @(posedge clk); @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        s_valid = 1'b0;
        check_val("out_valid_reached", {31'b0, out_valid}, 32'd1);
`ifndef INV_ROUND_SELFCHECK_EN
        if (!gaps) check_val("latency", cyc, n_eff + 1);
`endif
        check_val("nibbles_used", idx, n_eff);
        check_val("h_out", h_out, exp_h);
        check_val("check_ok", {31'b0, check_ok}, {31'b0, CHK_EXP});
        check_val("done_sready", {31'b0, s_ready}, 32'd0);
        check_val("done_busy", {31'b0, busy}, 32'd1);
        last_h = h_out;

        for (int unsigned k = 0; k < hold; k++) begin
            start = 1'b1; h_final = $urandom; num_rounds = 5'd3;
            s_valid = 1'b1; s_in = 4'($urandom_range(0, 15));
            @(posedge clk); @(negedge clk);
            check_val("hold_valid", {31'b0, out_valid}, 32'd1);
            check_val("hold_h", h_out, exp_h);
        end
        start = 1'b0; s_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check_val("release_valid", {31'b0, out_valid}, 32'd0);
        check_val("release_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_sready", {31'b0, s_ready}, 32'd0);
        check_val("rst_h", h_out, 32'd0);
        check_val("rst_chk", {31'b0, check_ok}, 32'd0);
        rst = 1'b0;

        run_job(32'h00000000, 1, 5, 1'b0, 0);
        check_val("vec_zero_s5", last_h, 32'h55555555);
        run_job(32'h80000000, 1, 0, 1'b0, 0);
        check_val("vec_msb", last_h, 32'h00000010);
        run_job(32'h00000100, 1, 0, 1'b0, 0);
        run_job($urandom, 0, -1, 1'b0, 0);
        check_val("zero_rounds_passthru", last_h, h_final);
        run_job($urandom, 16, -1, 1'b1, 0);
        run_job($urandom, 16, -1, 1'b0, 5);
        run_job($urandom, 23, -1, 1'b0, 0);
        for (int unsigned j = 0; j < 6; j++)
            run_job($urandom, $urandom_range(0, 16), -1, 1'(j & 1), $urandom_range(0, 2));

        // Reset partway through an 8-round job; nothing may come out of it.
        @(negedge clk);
        start = 1'b1; h_final = $urandom; num_rounds = 5'd8;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_in = 4'($urandom_range(0, 15));
            @(posedge clk); @(negedge clk);
        end
        check_val("midrun_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", {31'b0, busy}, 32'd0);
        check_val("midrst_sready", {31'b0, s_ready}, 32'd0);
        check_val("midrst_valid", {31'b0, out_valid}, 32'd0);
        check_val("midrst_h", h_out, 32'd0);
        check_val("midrst_chk", {31'b0, check_ok}, 32'd0);
        for (int unsigned k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_in = 4'($urandom_range(0, 15));
            @(posedge clk); @(negedge clk);
            check_val("post_rst_quiet", {30'b0, out_valid, busy}, 32'd0);
        end
        s_valid = 1'b0;
        run_job($urandom, 8, -1, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
